ysyx_24120013_regfile_sb: RTL and testbench
===========================================

// Module: ysyx_24120013_regfile_sb
// PURPOSE
//  Parametrised GPR file for the pipelined NPC core: NR_READ combinational read ports, one write port,
//  and a per-register busy scoreboard used by decode to detect RAW hazards.
//  Issue marks a destination busy; writeback writes data and clears busy; flush clears all busy bits.
//  Optional write->read bypass lets decode consume a value in its writeback cycle. Register 0 is hardwired to zero.
// PARAMETERS
//  ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  32  register data width
//  NR_READ     2   number of read ports (1..4)
//  BYPASS      1   1: same-cycle writeback data/busy-clear forwarded to reads; 0: reads see array/flops only
// PORTS
//  clk        in   1                   clock, all state updates on posedge
//  rst        in   1                   asynchronous, active-low reset
//  wen        in   1                   writeback valid
//  waddr      in   ADDR_WIDTH          writeback register index
//  wdata      in   DATA_WIDTH          writeback data
//  iss_valid  in   1                   issue of an instruction that writes iss_rd
//  iss_rd     in   ADDR_WIDTH          destination marked busy on issue
//  flush      in   1                   clear all busy bits (pipeline redirect)
//  raddr      in   NR_READ*ADDR_WIDTH  packed read indices, port i = [i*AW +: AW]
//  rdata      out  NR_READ*DATA_WIDTH  packed read data, port i = [i*DW +: DW]
//  rbusy      out  NR_READ             1 = port i's register has a pending write (hazard)
//  busy_cnt   out  ADDR_WIDTH+1        number of busy registers
// BEHAVIOUR
//  - Reset (rst=0, async): all registers 0, all busy bits 0, busy_cnt 0. rdata reads 0, rbusy reads 0
//    while in reset. Writes, issues and flushes are ignored until the first posedge after rst rises.
//  - Write: on posedge with wen=1 and waddr!=0, rf[waddr] <= wdata. waddr=0 writes are dropped; rf[0] is never stored.
//  - Read: combinational, zero latency. raddr=0 always gives rdata=0 and rbusy=0.
//  - Bypass (BYPASS=1): if wen=1 and waddr==raddr_i!=0, rdata_i=wdata and rbusy_i=0 in the same cycle.
//    This applies even if iss_valid with iss_rd==raddr_i in the same cycle; that issue shows busy from next cycle.
//    BYPASS=0: rdata_i is the old value and rbusy_i is the pre-edge busy bit.
//  - Busy update per posedge, register r!=0, in priority order:
//      1. flush=1: busy[r] <= 0 for all r, except busy[iss_rd] <= 1 if iss_valid (issue is post-redirect).
//      2. iss_valid && iss_rd==r: busy[r] <= 1. Issue wins over a same-cycle writeback to r.
//      3. wen && waddr==r: busy[r] <= 0.
//      4. otherwise hold.
//    iss_rd=0 never sets a busy bit. The data write in a flush cycle still happens.
//  - Writeback to a non-busy register is legal: data is written and busy stays 0.
//    Issuing to an already busy register is legal: busy stays 1. Single-outstanding-per-reg is the pipeline's responsibility.
//  - busy_cnt: registered popcount of busy bits, updated on the same edge as the busy bits; range 0..2**ADDR_WIDTH-1.
//  - Reset asserted mid-operation clears busy bits and data immediately. No pending write survives.
// TESTING
//  1. Reset: rst=0 with wen=1, waddr=3, wdata=32'hDEAD for 2 clks; release -> rdata[3]=0, rbusy=0, busy_cnt=0.
//  2. x0: wen=1, waddr=0, wdata=32'hFFFF_FFFF, raddr0=0 -> rdata0=0 same and next cycle; iss_rd=0 -> busy_cnt stays 0.
//  3. Scoreboard: issue rd=5 -> next cycle rbusy(raddr=5)=1, busy_cnt=1.
//     Wb waddr=5, wdata=32'h1234 -> same cycle (BYPASS=1) rdata=32'h1234 and rbusy=0; next cycle busy_cnt=0.
//  4. Collision: x7 busy; same edge iss_valid rd=7 and wen waddr=7 wdata=9 -> rf[7]=9, busy[7] stays 1, busy_cnt unchanged.
//  5. Flush: busy x1,x2,x3 (busy_cnt=3); flush=1 with iss_valid rd=4 -> next cycle only x4 busy, busy_cnt=1.
//  6. Multi-port/BYPASS=0: NR_READ=3, reads of x1/x2/x1 with wb x1=32'hA -> all ports old value that cycle,
//     32'hA on ports 0 and 2 the next cycle.

Source files
------------

// File: rtl/ysyx_24120013_regfile_sb.sv
// GPR file with a per-register busy scoreboard for RAW hazard detection.
// NR_READ combinational read ports, one write port, optional write->read
// bypass. Register 0 reads as zero and is never busy.
module ysyx_24120013_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wen,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           iss_valid,
  input  logic [ADDR_WIDTH-1:0]          iss_rd,
  input  logic                           flush,
  input  logic [NR_READ*ADDR_WIDTH-1:0]  raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]  rdata,
  output logic [NR_READ-1:0]             rbusy,
  output logic [ADDR_WIDTH:0]            busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_nxt;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic [ADDR_WIDTH-1:0] ra;

  // Next busy vector: issue is applied last so it beats both a same-cycle
  // writeback and a flush (the issue belongs to the redirected stream).
  always_comb begin
    busy_nxt = busy_q;
    if (flush)
      busy_nxt = '0;
    else if (wen)
      busy_nxt[waddr] = 1'b0;
    if (iss_valid)
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Popcount of the next busy vector so busy_cnt tracks busy_q exactly.
  always_comb begin
    cnt_nxt = '0;
    for (int r = 1; r < DEPTH; r++)
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[r]};
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Register array; x0 is held at zero and never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++)
        rf[r] <= '0;
    end else if (wen && (waddr != '0)) begin
      rf[waddr] <= wdata;
    end
  end

  // Combinational read ports with optional same-cycle writeback forwarding.
  // Outputs are forced to zero while reset is asserted so a bypassed write
  // cannot leak out during reset.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int i = 0; i < NR_READ; i++) begin
      ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (rst && (ra != '0)) begin
        if ((BYPASS != 0) && wen && (waddr == ra)) begin
          rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
          rbusy[i]                          = 1'b0;
        end else begin
          rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf[ra];
          rbusy[i]                          = busy_q[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24120013_regfile_sb.sv
// Bench for the regfile/scoreboard: two instances share write/issue/flush
// stimulus (A: 2 ports with bypass, B: 3 ports without). A driver pushes the
// expected outputs of each cycle into a queue; a monitor pops and compares.
module tb_ysyx_24120013_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;
  logic [9:0]  raddr_a;
  logic [14:0] raddr_b;
  logic [63:0] rdata_a;
  logic [95:0] rdata_b;
  logic [1:0]  rbusy_a;
  logic [2:0]  rbusy_b;
  logic [5:0]  cnt_a;
  logic [5:0]  cnt_b;

  always #5 clk = ~clk;

  ysyx_24120013_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a), .busy_cnt(cnt_a));

  ysyx_24120013_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(3), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b), .busy_cnt(cnt_b));

  typedef struct {
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic [5:0]  a_cnt;
    logic [95:0] b_rdata;
    logic [2:0]  b_rbusy;
    logic [5:0]  b_cnt;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural register values and pending-write flags.
  logic [31:0] m_rf   [32];
  bit          m_busy [32];

  function automatic int model_cnt();
    int c = 0;
    for (int r = 1; r < 32; r++) if (m_busy[r]) c++;
    return c;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp,
                                           input logic w, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (byp && w && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic logic model_busy(input logic [4:0] a, input bit byp,
                                      input logic w, input logic [4:0] wa);
    if (a == 5'd0) return 1'b0;
    if (byp && w && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = 32'd0;
      m_busy[r] = 1'b0;
    end
  endtask

  // One clock of stimulus: drive at negedge, record expected outputs for this
  // cycle, then advance the model to its post-edge state.
  task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic iv, input logic [4:0] ir, input logic fl,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic [4:0] b0, input logic [4:0] b1, input logic [4:0] b2);
    exp_t e;
    bit   nb;
    @(negedge clk);
    rst = r; wen = w; waddr = wa; wdata = wd;
    iss_valid = iv; iss_rd = ir; flush = fl;
    raddr_a = {a1, a0};
    raddr_b = {b2, b1, b0};
    if (!r) begin
      model_reset();
      e.a_rdata = '0; e.a_rbusy = '0; e.a_cnt = '0;
      e.b_rdata = '0; e.b_rbusy = '0; e.b_cnt = '0;
    end else begin
      e.a_rdata = {model_rd(a1, 1, w, wa, wd), model_rd(a0, 1, w, wa, wd)};
      e.a_rbusy = {model_busy(a1, 1, w, wa), model_busy(a0, 1, w, wa)};
      e.a_cnt   = 6'(model_cnt());
      e.b_rdata = {model_rd(b2, 0, w, wa, wd), model_rd(b1, 0, w, wa, wd), model_rd(b0, 0, w, wa, wd)};
      e.b_rbusy = {model_busy(b2, 0, w, wa), model_busy(b1, 0, w, wa), model_busy(b0, 0, w, wa)};
      e.b_cnt   = e.a_cnt;
    end
    expq.push_back(e);
    if (r) begin
      for (int k = 1; k < 32; k++) begin
        if (fl)                  nb = (iv && ir == 5'(k));
        else if (iv && ir == 5'(k)) nb = 1'b1;
        else if (w && wa == 5'(k))  nb = 1'b0;
        else                     nb = m_busy[k];
        m_busy[k] = nb;
      end
      if (w && wa != 5'd0) m_rf[wa] = wd;
    end
  endtask

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: outputs are steady two time units after the driving negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("a_rdata", 96'(rdata_a), 96'(e.a_rdata));
        chk("a_rbusy", 96'(rbusy_a), 96'(e.a_rbusy));
        chk("a_busy_cnt", 96'(cnt_a), 96'(e.a_cnt));
        chk("b_rdata", rdata_b, e.b_rdata);
        chk("b_rbusy", 96'(rbusy_b), 96'(e.b_rbusy));
        chk("b_busy_cnt", 96'(cnt_b), 96'(e.b_cnt));
      end
    end
  end

  initial begin
    logic [4:0] ra, rb;
    rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0; raddr_a = '0; raddr_b = '0;
    model_reset();

    // reset with a pending write that must be ignored
    cyc(0, 1, 3, 32'hDEAD, 0, 0, 0, 3, 3, 3, 3, 3);
    cyc(0, 1, 3, 32'hDEAD, 0, 0, 0, 3, 3, 3, 3, 3);
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3, 3);
    // x0 write and x0 issue
    cyc(1, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // issue then bypassed writeback of x5
    cyc(1, 0, 0, 0, 1, 5, 0, 5, 5, 5, 5, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5, 5);
    cyc(1, 1, 5, 32'h1234, 0, 0, 0, 5, 5, 5, 5, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5, 5);
    // issue/writeback collision on busy x7
    cyc(1, 0, 0, 0, 1, 7, 0, 7, 7, 7, 7, 7);
    cyc(1, 1, 7, 32'd9, 1, 7, 0, 7, 7, 7, 7, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 7, 7, 7, 7, 7);
    cyc(1, 1, 7, 32'd11, 0, 0, 0, 7, 0, 7, 0, 0);
    // flush with concurrent issue of x4
    cyc(1, 0, 0, 0, 1, 1, 0, 1, 2, 1, 2, 3);
    cyc(1, 0, 0, 0, 1, 2, 0, 1, 2, 1, 2, 3);
    cyc(1, 0, 0, 0, 1, 3, 0, 1, 2, 1, 2, 3);
    cyc(1, 0, 0, 0, 1, 4, 1, 1, 4, 1, 2, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 4, 3, 2, 4);
    // multi-port read during writeback of x1
    cyc(1, 1, 1, 32'hA, 0, 0, 0, 1, 2, 1, 2, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2, 1);
    // writeback to the top register and mid-operation reset
    cyc(1, 1, 31, 32'hCAFE_F00D, 1, 31, 0, 31, 4, 31, 4, 0);
    cyc(1, 0, 0, 0, 1, 9, 0, 31, 9, 31, 9, 4);
    cyc(0, 1, 9, 32'h55, 1, 6, 0, 31, 9, 31, 9, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, 31, 9, 31, 9, 4);

    // randomized traffic, addresses biased to a small window to force hits
    for (int n = 0; n < 600; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 1) == 1), rb, $urandom,
          ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 15) == 0),
          ra, rb, rb, ra, 5'($urandom_range(0, 7)));
    end

    // drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #3;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
